rv_fetch_queue: RTL and testbench
=================================

Name: rv_fetch_queue

Overview:
Parametrised instruction-fetch stage that replaces the single-register IF stage. It issues sequential PC requests to the synchronous instruction memory and buffers the returned {pc, inst} pairs in a DEPTH-entry FIFO. The FIFO decouples IF from ID through a valid/ready handshake. Branch redirects from EX flush the queue and any in-flight fetch, then restart fetch at the target.

Parameters:
XLEN, 64, PC/address width
DEPTH, 4, queue entries; power of two, >=2
RESET_PC, 64'h0, fetch PC after reset (low 2 bits must be 0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
im_req  output  1  instruction-memory read request this cycle
im_addr  output  XLEN  read address; always equals fetch_pc
im_dout  input  32  read data, valid exactly 1 cycle after im_req
branch_taken  input  1  redirect request from EX
branch_target  input  XLEN  redirect PC; bits [1:0] are ignored and treated as 0
inst_valid  output  1  head entry valid toward ID
inst_ready  input  1  ID accepts head entry
inst_out  output  32  head instruction; 0 when empty
pc_out  output  XLEN  head PC; 0 when empty
queue_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - fetch_pc=RESET_PC, so im_addr=RESET_PC.
  - im_req=0 in the reset cycle; the first request is issued in the first cycle after rst deasserts.
  - Queue empty, inst_valid=0, inst_out=0, pc_out=0, queue_count=0.
  - In-flight flag cleared.
- Issue: im_req=1 when !rst && !branch_taken && (queue_count + inflight) < DEPTH.
  - On issue: inflight<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (XLEN wrap-around, modulo 2^XLEN).
  - Otherwise inflight<=0.
- Response: in the cycle after an issue, if the response is not squashed, push {req_pc, im_dout} at the tail.
  - The credit rule guarantees a free slot, so a push never overflows the queue.
- Pop: when inst_valid && inst_ready, the head advances.
  - Pop and push in the same cycle: count unchanged, data ordering preserved.
  - Pop and push on a full queue is legal; the credit rule prevents push without room.
- Output: inst_valid = (queue_count != 0). inst_out/pc_out reflect the head combinationally from registered storage.
- Steady state: with inst_ready held high and DEPTH>=2, throughput is 1 instruction/cycle. First-instruction latency after reset or redirect is 2 cycles (issue, then push; visible the following cycle).
- Redirect (branch_taken=1), highest priority:
  - Next cycle: queue emptied (pointers reset, count=0) and fetch_pc=branch_target with [1:0] forced to 00.
  - Any response arriving next cycle from a request issued before or in the redirect cycle is dropped (squash flag).
  - No im_req in the redirect cycle.
  - A pop in the redirect cycle still completes toward ID; the ID/EX flush is the hazard unit's responsibility.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: identical to the reset values above; in-flight data is discarded.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count saturates at neither end; assertions flag overflow/underflow in simulation.

Optional Feature:
Macro RVCPU_FETCH_PERF_EN.
- Defined: adds outputs perf_redirects (32) and perf_empty_cycles (32).
  - perf_redirects increments on each cycle with branch_taken=1.
  - perf_empty_cycles increments on each cycle with inst_valid=0 and not in rst.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package rv_pkg:
  - XLEN_DEFAULT=64
  - INST_W=32
  - PC_STEP=4
  - NOP_INST=32'h0000_0013
  - typedef fetch_entry_t {pc[XLEN-1:0], inst[31:0]}
- Sub-module rv_sync_fifo (parametrised WIDTH, DEPTH) with push, pop, flush, count. The fetch-control logic (PC, credit, squash) stays in rv_fetch_queue.

Test Plan:
- Reset release, RESET_PC=0x1000, ready=1, memory returns addr-derived data → im_addr 0x1000, 0x1004, 0x1008… on consecutive cycles; first inst_valid 2 cycles after rst deasserts with pc_out=0x1000; then one entry/cycle in order.
- inst_ready=0 for 10 cycles, DEPTH=4 → exactly 4 entries buffered (queue_count=4), im_req=0 afterwards. Release ready → PCs 0x1000..0x100C are drained, then fetch resumes at 0x1010 with no gap or duplicate.
- branch_taken with target 0x2002 while the queue holds 3 entries and a fetch is in flight → next cycle count=0 and the in-flight data is not enqueued; next request at im_addr 0x2000; next valid pc_out=0x2000.
- Redirect asserted on 2 consecutive cycles (0x3000 then 0x4000) → the only subsequent fetch starts at 0x4000; no 0x3000 entry ever appears.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC → next issued im_addr=0x0; entry order intact.
- rst asserted mid-stream with a full queue → next cycle inst_valid=0, queue_count=0; the first request after rst deasserts is at RESET_PC. With RVCPU_FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-path constants, entry layout and small helpers.
package rv_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int INST_W       = 32;
    localparam int PC_STEP      = 4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INST_W-1:0]       inst;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rv_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response, EX redirect and the IF->ID handshake.
interface rv_fetch_queue_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    import rv_pkg::*;

    logic                    im_req;
    logic [XLEN-1:0]         im_addr;
    logic [INST_W-1:0]       im_dout;
    logic                    branch_taken;
    logic [XLEN-1:0]         branch_target;
    logic                    inst_valid;
    logic                    inst_ready;
    logic [INST_W-1:0]       inst_out;
    logic [XLEN-1:0]         pc_out;
    logic [$clog2(DEPTH):0]  queue_count;

    modport master (
        output im_req, im_addr, inst_valid, inst_out, pc_out, queue_count,
        input  im_dout, branch_taken, branch_target, inst_ready
    );

    modport slave (
        input  im_req, im_addr, inst_valid, inst_out, pc_out, queue_count,
        output im_dout, branch_taken, branch_target, inst_ready
    );

endinterface

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush; head data reads as zero when empty.
module rv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush beats push/pop: a redirect discards everything, including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        pop_data = '0;
        if (count != '0) pop_data = mem[rd_ptr];
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && !pop && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(pop && count == '0));

endmodule

// File: rtl/rv_fetch_queue.sv
// Queued instruction-fetch stage: sequential PC issue, {pc, inst} FIFO, redirect flush.
// Optional perf counters under RVCPU_FETCH_PERF_EN.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    rv_fetch_queue_if.master  fq
`ifdef RVCPU_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_empty_cycles
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + INST_W;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic            squash;
    logic            issue;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic [EW-1:0]   head;

    // An outstanding request already owns a slot, so count it before issuing another.
    always_comb begin
        credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
        issue       = !rst && !fq.branch_taken && (credit_used < (CW+1)'(DEPTH));
        push        = inflight && !squash;
        pop         = (count != '0) && fq.inst_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
        end else begin
            inflight <= issue;
            squash   <= fq.branch_taken;
            if (fq.branch_taken) begin
                fetch_pc <= fq.branch_target & ~XLEN'(3);
            end else if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end
        end
    end

    rv_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fq.branch_taken),
        .push      (push),
        .push_data ({req_pc, fq.im_dout}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    always_comb begin
        fq.im_req      = issue;
        fq.im_addr     = fetch_pc;
        fq.inst_valid  = (count != '0);
        fq.pc_out      = head[EW-1:INST_W];
        fq.inst_out    = head[INST_W-1:0];
        fq.queue_count = count;
    end

`ifdef RVCPU_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirects    <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (fq.branch_taken) perf_redirects <= sat_inc32(perf_redirects);
            if (count == '0)     perf_empty_cycles <= sat_inc32(perf_empty_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue with a queue-level reference model checked every cycle.
module tb_rv_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h1000;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   seen_3000 = 0;

    rv_fetch_queue_if #(.XLEN(64), .DEPTH(DEPTH)) bus ();

`ifdef RVCPU_FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_empty_cycles;
`endif

    rv_fetch_queue #(
        .XLEN     (64),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bus)
`ifdef RVCPU_FETCH_PERF_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h13C0_0000;
    endfunction

    // Synchronous instruction memory: data for a request appears in the next cycle only.
    always @(posedge clk) begin
        if (bus.im_req) bus.im_dout <= mem_word(bus.im_addr);
        else            bus.im_dout <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of {pc, inst}, a fetch PC and a pending-request slot.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] m_pc;
    logic [63:0] m_rpc;
    bit          m_infl;
    bit          m_sq;
    longint      m_redir;
    longint      m_empty;

    initial begin
        bit req;
        bit pop;
        m_pc = RESET_PC; m_rpc = '0; m_infl = 0; m_sq = 0; m_redir = 0; m_empty = 0;
        @(posedge clk);
        forever begin
            req = !rst && !bus.branch_taken && ((mq.size() + int'(m_infl)) < DEPTH);
            pop = (mq.size() != 0) && bus.inst_ready;
            if (rst) begin
                mq.delete(); m_pc = RESET_PC; m_infl = 0; m_sq = 0; m_redir = 0; m_empty = 0;
            end else begin
                if (bus.branch_taken) m_redir++;
                if (mq.size() == 0) m_empty++;
                if (bus.branch_taken) begin
                    mq.delete();
                    m_pc = bus.branch_target & ~64'h3;
                end else begin
                    if (pop) void'(mq.pop_front());
                    if (m_infl && !m_sq) mq.push_back('{m_rpc, mem_word(m_rpc)});
                    if (req) begin
                        m_rpc = m_pc;
                        m_pc  = m_pc + 64'd4;
                    end
                end
                m_infl = req;
                m_sq   = bus.branch_taken;
            end
            @(negedge clk);
            chk("im_req", 64'(bus.im_req),
                64'(!rst && !bus.branch_taken && ((mq.size() + int'(m_infl)) < DEPTH)));
            chk("im_addr", bus.im_addr, m_pc);
            chk("inst_valid", 64'(bus.inst_valid), 64'(mq.size() != 0));
            chk("queue_count", 64'(bus.queue_count), 64'(mq.size()));
            chk("pc_out", bus.pc_out, (mq.size() != 0) ? mq[0].pc : 64'h0);
            chk("inst_out", 64'(bus.inst_out), (mq.size() != 0) ? 64'(mq[0].inst) : 64'h0);
`ifdef RVCPU_FETCH_PERF_EN
            chk("perf_redirects", 64'(perf_redirects), 64'(m_redir));
            chk("perf_empty_cycles", 64'(perf_empty_cycles), 64'(m_empty));
`endif
            if (bus.inst_valid && bus.pc_out[63:12] == 52'h3) seen_3000++;
            @(posedge clk);
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        bus.inst_ready    = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;

        // Reset values and first-fetch latency
        repeat (2) step();
        @(negedge clk);
        chk("rst_im_req", 64'(bus.im_req), 64'h0);
        chk("rst_im_addr", bus.im_addr, 64'h1000);
        chk("rst_count", 64'(bus.queue_count), 64'h0);
        chk("rst_pc_out", bus.pc_out, 64'h0);
        chk("rst_inst_out", 64'(bus.inst_out), 64'h0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("c0_im_req", 64'(bus.im_req), 64'h1);
        chk("c0_im_addr", bus.im_addr, 64'h1000);
        chk("c0_valid", 64'(bus.inst_valid), 64'h0);
        step(); @(negedge clk);
        chk("c1_im_addr", bus.im_addr, 64'h1004);
        chk("c1_valid", 64'(bus.inst_valid), 64'h0);
        step(); @(negedge clk);
        chk("c2_valid", 64'(bus.inst_valid), 64'h1);
        chk("c2_pc_out", bus.pc_out, 64'h1000);
        chk("c2_inst_out", 64'(bus.inst_out), 64'(mem_word(64'h1000)));
        step(); @(negedge clk);
        chk("c3_pc_out", bus.pc_out, 64'h1004);

        // Back-pressure fills the queue, then reset mid-stream
        step(); bus.inst_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("full_count", 64'(bus.queue_count), 64'h4);
        step(); rst = 1'b1;
        step(); @(negedge clk);
        chk("midrst_valid", 64'(bus.inst_valid), 64'h0);
        chk("midrst_count", 64'(bus.queue_count), 64'h0);
        chk("midrst_addr", bus.im_addr, 64'h1000);
`ifdef RVCPU_FETCH_PERF_EN
        chk("midrst_perf_redir", 64'(perf_redirects), 64'h0);
        chk("midrst_perf_empty", 64'(perf_empty_cycles), 64'h0);
`endif
        step(); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_addr", bus.im_addr, 64'h1000);
        chk("post_rst_req", 64'(bus.im_req), 64'h1);

        // Stall from reset: exactly DEPTH entries, then drain without gap
        repeat (10) step();
        @(negedge clk);
        chk("stall_count", 64'(bus.queue_count), 64'h4);
        chk("stall_req", 64'(bus.im_req), 64'h0);
        step(); bus.inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("drain_pc", bus.pc_out, 64'h1000 + 64'(4 * k));
            step();
        end
        repeat (3) step();

        // Redirect with 3 queued entries and a fetch in flight
        bus.inst_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.queue_count == 3'd3) found = 1;
            else step();
        end
        if (!found) chk("wait_count3", 64'(bus.queue_count), 64'h3);
        #1;
        bus.branch_taken = 1'b1; bus.branch_target = 64'h2002;
        #1 chk("redir_no_req", 64'(bus.im_req), 64'h0);
        step(); bus.branch_taken = 1'b0; bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("redir_count", 64'(bus.queue_count), 64'h0);
        chk("redir_addr", bus.im_addr, 64'h2000);
        step(); @(negedge clk);
        chk("redir_valid_gap", 64'(bus.inst_valid), 64'h0);
        step(); @(negedge clk);
        chk("redir_pc", bus.pc_out, 64'h2000);

        // Back-to-back redirects: the later one wins
        step(); bus.branch_taken = 1'b1; bus.branch_target = 64'h3000;
        step(); bus.branch_target = 64'h4000;
        step(); bus.branch_taken = 1'b0;
        @(negedge clk);
        chk("b2b_addr", bus.im_addr, 64'h4000);
        step(); step(); @(negedge clk);
        chk("b2b_pc", bus.pc_out, 64'h4000);

        // PC wrap-around at the top of the address space
        step(); bus.branch_taken = 1'b1; bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step(); bus.branch_taken = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", bus.im_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(); @(negedge clk);
        chk("wrap_addr1", bus.im_addr, 64'h0);
        step(); @(negedge clk);
        chk("wrap_pc0", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        step(); @(negedge clk);
        chk("wrap_pc1", bus.pc_out, 64'h0);
        chk("wrap_inst1", 64'(bus.inst_out), 64'h13C0_0000);

        repeat (5) step();
        chk("no_0x3000_entry", 64'(seen_3000), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
